// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding, register addresses and CTRL field positions for the LED pattern generator
package led_pkg;
  typedef enum logic [1:0] {
    LED_STATIC = 2'd0,
    LED_BLINK  = 2'd1,
    LED_CHASE  = 2'd2,
    LED_PWM    = 2'd3
  } led_mode_e;
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_DUTY    = 2'd3;
  localparam int CTRL_MODE_LSB = 0;
  localparam int CTRL_MODE_W   = 2;
  localparam int CTRL_EN_BIT   = 2;
endpackage

// File: rtl/led_pattern_gen_if.sv
// led_pattern_gen_if: single-cycle register write port (wr_en strobe, wr_addr select, wr_data payload)
interface led_pattern_gen_if;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [31:0] wr_data;
  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/led_prescaler.sv
// led_prescaler: counts 0..period while enabled, tick in the cycle the count equals period (clk, rst, en, period, restart -> tick)
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  input  logic             restart,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && !restart && cnt_q == period;
    cnt_d = (!en || restart || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: programmable static/blink/chase/pwm LED source (in_clk, in_rst, wr register bus -> out_mem LED word, out_tick prescaler wrap)
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int               LED_W      = 6,
  parameter int               DIV_W      = 24,
  parameter logic [DIV_W-1:0] DEF_PERIOD = DIV_W'(4_999_999)
) (
  input  logic               in_clk,
  input  logic               in_rst,
  led_pattern_gen_if.slave   wr,
  output logic [LED_W-1:0]   out_mem,
  output logic               out_tick
);
  led_mode_e        mode_q, mode_d;
  logic             en_q, en_d, phase_q, phase_d;
  logic [LED_W-1:0] pat_q, pat_d, chase_q, chase_d, out_q, out_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [3:0]       duty_q, duty_d, pwm_q, pwm_d;
  logic             wr_ctrl, wr_pat, wr_per, wr_duty, restart, tick;
  logic             unused_wr_data;
  assign wr_ctrl        = wr.wr_en && wr.wr_addr == ADDR_CTRL;
  assign wr_pat         = wr.wr_en && wr.wr_addr == ADDR_PATTERN;
  assign wr_per         = wr.wr_en && wr.wr_addr == ADDR_PERIOD;
  assign wr_duty        = wr.wr_en && wr.wr_addr == ADDR_DUTY;
  assign restart        = wr_ctrl || wr_per;
  assign unused_wr_data = ^wr.wr_data[31:DIV_W];
  led_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk     (in_clk),
    .rst     (in_rst),
    .en      (en_q),
    .period  (period_q),
    .restart (restart),
    .tick    (tick)
  );
  always_comb begin
    mode_d   = wr_ctrl ? led_mode_e'(wr.wr_data[CTRL_MODE_LSB +: CTRL_MODE_W]) : mode_q;
    en_d     = wr_ctrl ? wr.wr_data[CTRL_EN_BIT] : en_q;
    pat_d    = wr_pat  ? wr.wr_data[LED_W-1:0] : pat_q;
    period_d = wr_per  ? wr.wr_data[DIV_W-1:0] : period_q;
    duty_d   = wr_duty ? wr.wr_data[3:0] : duty_q;
    phase_d  = restart ? 1'b0 : tick ? !phase_q : phase_q;
    pwm_d    = restart ? 4'd0 : tick ? pwm_q + 1'b1 : pwm_q;
    // a pattern load beats a same-cycle rotate so the new pattern shows unrotated
    chase_d  = (restart || wr_pat) ? pat_d : tick ? {chase_q[LED_W-2:0], chase_q[LED_W-1]} : chase_q;
    out_d    = !en_d                ? '0 :
               mode_d == LED_STATIC ? pat_d :
               mode_d == LED_BLINK  ? (phase_d ? '0 : pat_d) :
               mode_d == LED_CHASE  ? chase_d :
               (pwm_d < duty_d)     ? pat_d : '0;
  end
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      mode_q   <= LED_STATIC;
      en_q     <= 1'b0;
      pat_q    <= '0;
      period_q <= DEF_PERIOD;
      duty_q   <= 4'd0;
      phase_q  <= 1'b0;
      pwm_q    <= 4'd0;
      chase_q  <= '0;
      out_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      en_q     <= en_d;
      pat_q    <= pat_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      phase_q  <= phase_d;
      pwm_q    <= pwm_d;
      chase_q  <= chase_d;
      out_q    <= out_d;
    end
  end
  assign out_mem  = out_q;
  assign out_tick = tick;
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed and random register writes checked every cycle against a tick-counting reference model
module tb_led_pattern_gen;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] out_mem;
  logic       out_tick;
  led_pattern_gen_if bus ();
  led_pattern_gen dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .wr       (bus),
    .out_mem  (out_mem),
    .out_tick (out_tick)
  );
  always #5 clk = ~clk;
  int     tests = 0, fails = 0;
  int     m_mode, m_en, m_pat, m_duty, ticks, cbase, cticks, exp_out;
  longint m_period, cyc;
  function automatic int rotl(input int b, input int k);
    return ((b << k) | (b >> (6 - k))) & 63;
  endfunction
  function automatic int model_out();
    if (m_en == 0) return 0;
    case (m_mode)
      0:       return m_pat;
      1:       return (ticks % 2) ? 0 : m_pat;
      2:       return rotl(cbase, cticks % 6);
      default: return ((ticks % 16) < m_duty) ? m_pat : 0;
    endcase
  endfunction
  task automatic model_reset();
    m_mode = 0; m_en = 0; m_pat = 0; m_duty = 0; m_period = 4_999_999;
    cyc = 0; ticks = 0; cbase = 0; cticks = 0; exp_out = 0;
  endtask
  task automatic step(input logic r, input logic we, input logic [1:0] a, input logic [31:0] d, input string tag);
    logic restart, tk;
    rst = r; bus.wr_en = we; bus.wr_addr = a; bus.wr_data = d;
    #1;
    restart = we && (a == 2'd0 || a == 2'd2);
    tk = m_en != 0 && !restart && (cyc % (m_period + 1)) == m_period;
    tests++;
    assert (out_mem === 6'(exp_out)) else begin
      fails++;
      $error("FAIL %s out_mem got %h expected %h", tag, out_mem, 6'(exp_out));
    end
    tests++;
    assert (out_tick === tk) else begin
      fails++;
      $error("FAIL %s out_tick got %b expected %b", tag, out_tick, tk);
    end
    if (r) model_reset();
    else begin
      if (we) case (a)
        2'd0: begin m_mode = int'(d[1:0]); m_en = int'(d[2]); end
        2'd1: m_pat = int'(d[5:0]);
        2'd2: m_period = longint'(d[23:0]);
        default: m_duty = int'(d[3:0]);
      endcase
      if (restart) begin cyc = 0; ticks = 0; cbase = m_pat; cticks = 0; end
      else begin
        cyc++;
        if (tk) begin ticks++; cticks++; end
      end
      if (we && a == 2'd1) begin cbase = m_pat; cticks = 0; end
      exp_out = model_out();
    end
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input string tag);
    step(1'b0, 1'b1, a, d, tag);
  endtask
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd0, 32'd0, tag);
  endtask
  initial begin
    logic [31:0] r, d;
    logic [1:0]  a;
    rst = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = 32'd0;
    @(negedge clk); @(negedge clk);
    model_reset();
    idle(100, "reset_idle");
    wr(2'd1, 32'h2A, "pat_disabled"); idle(5, "disabled_hold");
    wr(2'd0, 32'h4, "ctrl_static"); wr(2'd1, 32'h33, "pat_static"); idle(20, "static_hold");
    wr(2'd2, 32'd3, "per3"); wr(2'd1, 32'h01, "pat_chase"); wr(2'd0, 32'h6, "ctrl_chase");
    idle(30, "chase_run");
    wr(2'd2, 32'd1, "per1"); wr(2'd1, 32'h3F, "pat_blink"); wr(2'd0, 32'h5, "ctrl_blink");
    idle(9, "blink_run"); wr(2'd2, 32'd1, "per_midrun"); idle(10, "blink_restart");
    wr(2'd2, 32'd0, "per0"); wr(2'd3, 32'd4, "duty4"); wr(2'd1, 32'h0F, "pat_pwm");
    wr(2'd0, 32'h7, "ctrl_pwm"); idle(40, "pwm4_run");
    wr(2'd3, 32'd0, "duty0"); idle(20, "pwm0_run");
    wr(2'd3, 32'd15, "duty15"); idle(20, "pwm15_run");
    wr(2'd0, 32'h6, "ctrl_chase2"); wr(2'd1, 32'h01, "pat_chase2"); wr(2'd2, 32'd2, "per2");
    idle(2, "chase2_pre"); wr(2'd1, 32'h05, "pat_on_tick"); idle(10, "chase2_run");
    step(1'b1, 1'b1, 2'd1, 32'h3F, "rst_with_write"); idle(3, "after_rst");
    wr(2'd0, 32'h6, "ctrl_after_rst"); wr(2'd1, 32'h21, "pat_after_rst");
    idle(200, "def_period_no_tick");
    wr(2'd2, 32'hFF00_0000, "per_upper_ignored"); idle(10, "per0_upper");
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      if (r % 97 == 0) step(1'b1, 1'b0, 2'd0, 32'd0, "rnd_rst");
      else if (r % 5 == 0) begin
        a = r[9:8];
        d = $urandom;
        if (a == 2'd2) d = {d[31:24], 21'd0, d[2:0]};
        wr(a, d, "rnd_wr");
      end else step(1'b0, 1'b0, r[9:8], $urandom, "rnd_idle");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
